// File: rtl/fht_bank_writer.sv
// FHT stage write-back sequencer: delays each accepted 4-bank read by LAT cycles
// and turns it into the matching bank write of the butterfly results.
module fht_bank_writer #(
    parameter int D_BIT = 17,
    parameter int A_BIT = 8,
    parameter int LAT   = 3
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iSTART,
    input  logic                    iST_LAST,
    input  logic                    iRD_VALID,
    input  logic [A_BIT-1:0]        iRD_ADDR,
    input  logic [3:0]              iWR_MASK,
    input  logic signed [D_BIT-1:0] iY_0,
    input  logic signed [D_BIT-1:0] iY_1,
    input  logic signed [D_BIT-1:0] iY_2,
    input  logic signed [D_BIT-1:0] iY_3,
    output logic [3:0]              oWR_EN,
    output logic [A_BIT-1:0]        oWR_ADDR,
    output logic signed [D_BIT-1:0] oWR_DATA_0,
    output logic signed [D_BIT-1:0] oWR_DATA_1,
    output logic signed [D_BIT-1:0] oWR_DATA_2,
    output logic signed [D_BIT-1:0] oWR_DATA_3,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oLAST_DONE,
    output logic                    oERR
);
    localparam logic [A_BIT:0] N_ROWS  = {1'b1, {A_BIT{1'b0}}};
    localparam logic [A_BIT:0] LAST_RD = {1'b0, {A_BIT{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                     state;
    logic                       st_last;
    logic [A_BIT:0]             rd_cnt, wr_cnt, wr_cnt_nxt;
    logic                       busy_q, done_q, last_q, err_q;
    logic                       rd_acc, start_ok, err_evt, out_vld;

    logic [LAT:1]               vld_pipe;
    logic [LAT:1][A_BIT-1:0]    addr_pipe;
    logic [LAT:1][3:0]          mask_pipe;
    logic [A_BIT-1:0]           addr_q;
    logic                       have_y;
    logic [3:0][D_BIT-1:0]      y_in, y_q, wr_data;

    assign out_vld    = vld_pipe[LAT];
    assign rd_acc     = (state == S_RUN) && iRD_VALID && (rd_cnt != N_ROWS);
    assign start_ok   = (state == S_IDLE) && iSTART;
    assign err_evt    = (iSTART && (state != S_IDLE)) || (iRD_VALID && !rd_acc);
    assign wr_cnt_nxt = wr_cnt + {{A_BIT{1'b0}}, out_vld};

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state   <= S_IDLE;
            st_last <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            last_q <= 1'b0;
            // a new error in the same cycle as an accepted start still wins
            if (err_evt)       err_q <= 1'b1;
            else if (start_ok) err_q <= 1'b0;
            wr_cnt <= wr_cnt_nxt;
            if (rd_acc) rd_cnt <= rd_cnt + {{A_BIT{1'b0}}, 1'b1};
            case (state)
                S_IDLE: if (iSTART) begin
                    state   <= S_RUN;
                    st_last <= iST_LAST;
                    rd_cnt  <= '0;
                    wr_cnt  <= '0;
                    busy_q  <= 1'b1;
                end
                S_RUN:   if (rd_acc && rd_cnt == LAST_RD) state <= S_FLUSH;
                S_FLUSH: if (wr_cnt_nxt == N_ROWS) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    last_q <= st_last;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            mask_pipe <= '0;
            addr_q    <= '0;
            have_y    <= 1'b0;
            y_q       <= '0;
        end else begin
            vld_pipe[1]  <= rd_acc;
            addr_pipe[1] <= rd_acc ? iRD_ADDR : '0;
            mask_pipe[1] <= rd_acc ? iWR_MASK : 4'h0;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                mask_pipe[i] <= mask_pipe[i-1];
            end
            if (out_vld) begin
                addr_q <= addr_pipe[LAT];
                y_q    <= y_in;
                have_y <= 1'b1;
            end
        end
    end

    assign y_in = {iY_3, iY_2, iY_1, iY_0};

    // data is live from the butterfly during a write; otherwise the last written value is held
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign wr_data[k] = (out_vld || !have_y) ? y_in[k] : y_q[k];
    end

    assign oWR_EN     = out_vld ? mask_pipe[LAT] : 4'h0;
    assign oWR_ADDR   = out_vld ? addr_pipe[LAT] : addr_q;
    assign oWR_DATA_0 = wr_data[0];
    assign oWR_DATA_1 = wr_data[1];
    assign oWR_DATA_2 = wr_data[2];
    assign oWR_DATA_3 = wr_data[3];
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oLAST_DONE = last_q;
    assign oERR       = err_q;
endmodule

// File: tb/tb_fht_bank_writer.sv
// Scoreboard bench for fht_bank_writer (A_BIT=2, LAT=3): the driver predicts writes,
// done pulses and flags from stage-level rules; a negedge monitor compares.
module tb_fht_bank_writer;
    localparam int D = 17, A = 2, L = 3, NR = 4;

    logic iCLK = 0, iRESET = 0, iSTART = 0, iST_LAST = 0, iRD_VALID = 0;
    logic [A-1:0] iRD_ADDR = '0;
    logic [3:0] iWR_MASK = '0;
    logic signed [D-1:0] iY_0, iY_1, iY_2, iY_3;
    logic [3:0] oWR_EN;
    logic [A-1:0] oWR_ADDR;
    logic signed [D-1:0] oWR_DATA_0, oWR_DATA_1, oWR_DATA_2, oWR_DATA_3;
    logic oBUSY, oDONE, oLAST_DONE, oERR;

    fht_bank_writer #(.D_BIT(D), .A_BIT(A), .LAT(L)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iST_LAST(iST_LAST),
        .iRD_VALID(iRD_VALID), .iRD_ADDR(iRD_ADDR), .iWR_MASK(iWR_MASK),
        .iY_0(iY_0), .iY_1(iY_1), .iY_2(iY_2), .iY_3(iY_3),
        .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR),
        .oWR_DATA_0(oWR_DATA_0), .oWR_DATA_1(oWR_DATA_1),
        .oWR_DATA_2(oWR_DATA_2), .oWR_DATA_3(oWR_DATA_3),
        .oBUSY(oBUSY), .oDONE(oDONE), .oLAST_DONE(oLAST_DONE), .oERR(oERR));

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef logic [3:0][D-1:0] yvec_t;
    typedef struct packed { int cyc; logic [A-1:0] addr; logic [3:0] mask; yvec_t y; } wr_t;
    typedef struct packed { int cyc; logic last; } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    yvec_t sched[int];

    // stage-level model
    bit stage_open = 0, cur_last = 0, m_err = 0, m_busy = 0;
    int start_cyc = 0, nacc = 0, done_cyc = -1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    endtask

    task automatic drive_y(int c);
        yvec_t yv;
        if (sched.exists(c)) yv = sched[c];
        else for (int k = 0; k < 4; k++) yv[k] = D'($urandom());
        iY_0 = yv[0]; iY_1 = yv[1]; iY_2 = yv[2]; iY_3 = yv[3];
    endtask

    task automatic step(input bit st, input bit last, input bit rv,
                        input logic [A-1:0] a, input logic [3:0] m);
        int c = cyc;
        bit evt = 0, st_ok = 0, nx_err, nx_busy;
        yvec_t yv;
        if (stage_open && done_cyc >= 0 && c > done_cyc) stage_open = 0;
        iSTART = st; iST_LAST = last; iRD_VALID = rv; iRD_ADDR = a; iWR_MASK = m;
        drive_y(c);
        if (rv) begin
            if (stage_open && c > start_cyc && nacc < NR) begin
                for (int k = 0; k < 4; k++) yv[k] = D'($urandom());
                sched[c + L] = yv;
                exp_wr.push_back('{cyc: c + L, addr: a, mask: m, y: yv});
                nacc++;
                if (nacc == NR) begin
                    done_cyc = c + L + 1;
                    exp_done.push_back('{cyc: done_cyc, last: cur_last});
                end
            end else evt = 1;
        end
        if (st) begin
            if (!stage_open) begin
                st_ok = 1; stage_open = 1; start_cyc = c; nacc = 0; done_cyc = -1; cur_last = last;
            end else evt = 1;
        end
        nx_err  = (st_ok ? 1'b0 : m_err) | evt;
        nx_busy = stage_open && (done_cyc < 0 || c + 1 < done_cyc);
        @(posedge iCLK); #1;
        m_err = nx_err; m_busy = nx_busy;
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, '0, 4'h0);
    endtask

    task automatic do_reset(int n);
        iRESET = 0; iSTART = 0; iRD_VALID = 0;
        exp_wr.delete(); exp_done.delete(); sched.delete();
        stage_open = 0; m_err = 0; m_busy = 0;
        drive_y(cyc);
        repeat (n) begin @(posedge iCLK); #1; drive_y(cyc); end
        iRESET = 1;
    endtask

    // monitor
    logic [A-1:0] last_addr = '0;
    yvec_t last_y = '0;
    bit have_y = 0;
    always @(negedge iCLK) begin
        yvec_t act_y, in_y;
        wr_t e;
        done_t d;
        act_y = {oWR_DATA_3, oWR_DATA_2, oWR_DATA_1, oWR_DATA_0};
        in_y  = {iY_3, iY_2, iY_1, iY_0};
        if (!iRESET) begin
            have_y = 0; last_addr = '0;
            chk("rst_en", oWR_EN, 0);
            chk("rst_addr", oWR_ADDR, 0);
            chk("rst_data", act_y, in_y);
            chk("rst_flags", {oBUSY, oDONE, oLAST_DONE, oERR}, 0);
        end else begin
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                e = exp_wr.pop_front();
                chk("wr_en", oWR_EN, e.mask);
                chk("wr_addr", oWR_ADDR, e.addr);
                chk("wr_data", act_y, e.y);
                last_addr = e.addr; last_y = e.y; have_y = 1;
            end else begin
                chk("idle_en", oWR_EN, 0);
                chk("hold_addr", oWR_ADDR, last_addr);
                chk("hold_data", act_y, have_y ? last_y : in_y);
            end
            if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
                d = exp_done.pop_front();
                chk("done", {oDONE, oLAST_DONE}, {1'b1, d.last});
            end else chk("no_done", {oDONE, oLAST_DONE}, 0);
            chk("busy", oBUSY, m_busy);
            chk("err", oERR, m_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        drive_y(0);
        do_reset(3);
        idle(2);
        // nominal
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, A'(i), 4'hF);
        idle(6);
        // gapped
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 4'hF); step(0, 0, 1, 1, 4'hF);
        idle(1);
        step(0, 0, 1, 2, 4'hF); step(0, 0, 1, 3, 4'hF);
        idle(7);
        // last stage with mixed masks including a zero mask
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 4'h5); step(0, 0, 1, 1, 4'hA);
        step(0, 0, 1, 2, 4'hF); step(0, 0, 1, 3, 4'h0);
        idle(6);
        // errors: read in IDLE, start+read together, start in RUN, 5th read
        step(0, 0, 1, 1, 4'hF);
        step(1, 0, 1, 1, 4'hF);
        step(0, 0, 1, 3, 4'hF); step(1, 1, 1, 2, 4'h3);
        step(0, 0, 1, 1, 4'hC); step(0, 0, 1, 0, 4'hF);
        step(0, 0, 1, 2, 4'hF);
        idle(7);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, A'(3 - i), 4'h9);
        idle(7);
        // reset after two writes, then a clean stage
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, A'(i), 4'hF);
        idle(1);
        do_reset(2);
        idle(1);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, A'(i), 4'h6);
        idle(7);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
            else step($urandom_range(0, 7) == 0, 1'($urandom()), $urandom_range(0, 9) < 6,
                      A'($urandom()), 4'($urandom()));
        end
        idle(12);
        chk("wr_q_empty", exp_wr.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
